// File: rtl/branch_unit.sv
// ============================================================================
//  Module   : branch_unit
//  Brief    : Execute-stage branch resolution with NZCV flags, redirect pulse,
//             flush window and saturating branch counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_unit #(
    parameter int OP_BITS      = 5,
    parameter int COND_BITS    = 4,
    parameter int ADDR_W       = 16,
    parameter int OFF_W        = 11,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [OP_BITS-1:0]   opcode,
    input  logic [ADDR_W-1:0]    pc_in,
    input  logic [OFF_W-1:0]     offset,
    input  logic                 flags_we,
    input  logic [COND_BITS-1:0] flags_in,
    output logic [COND_BITS-1:0] flags_q,
    output logic                 redirect,
    output logic [ADDR_W-1:0]    target,
    output logic                 flush,
    output logic                 busy,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     taken_cnt
);

    localparam int C_FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [C_FC_W-1:0] C_FC_LOAD = C_FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    logic [C_FC_W-1:0]  r_fc;

    logic [COND_BITS-1:0] w_eff;
    logic                 w_z, w_n, w_v, w_s;
    logic                 w_req;
    logic                 w_cond;
    logic                 w_acc;
    logic                 w_taken;
    logic [ADDR_W-1:0]    w_off_ext;
    logic [ADDR_W-1:0]    w_target;

    // Flags written this cycle are visible to a branch in the same cycle.
    assign w_eff = flags_we ? flags_in : flags_q;
    assign w_z   = w_eff[0];
    assign w_n   = w_eff[2];
    assign w_v   = w_eff[3];
    assign w_s   = ~(w_n ^ w_v);

    assign w_req = (opcode[4] & opcode[3]) |
                   (opcode[4] & ~opcode[3] & opcode[1] & opcode[0]);

    always_comb begin
        w_cond = 1'b0;
        case (opcode[2:0])
            3'b000:  w_cond = 1'b1;
            3'b001:  w_cond = ~w_z & w_s;
            3'b010:  w_cond = w_z;
            3'b011:  w_cond = w_s;
            3'b100:  w_cond = ~w_s;
            3'b101:  w_cond = ~w_z;
            3'b110:  w_cond = ~(~w_z & w_s);
            default: w_cond = 1'b1;
        endcase
    end

    assign w_acc   = valid_in & w_req & (r_state == IDLE);
    assign w_taken = w_acc & w_cond;

    generate
        if (OFF_W < ADDR_W) begin : g_sext
            assign w_off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
        end else begin : g_nosext
            assign w_off_ext = offset;
        end
    endgenerate

    assign w_target = pc_in + w_off_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_fc     <= '0;
            redirect <= 1'b0;
            target   <= '0;
            flush    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_taken) begin
                        r_state  <= FLUSH;
                        r_fc     <= C_FC_LOAD;
                        redirect <= 1'b1;
                        target   <= w_target;
                        flush    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FLUSH: begin
                    // The redirect cycle counts as the first flush cycle.
                    if (r_fc == '0) begin
                        r_state <= IDLE;
                        flush   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_fc <= r_fc - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (w_acc && branch_cnt != C_CNT_MAX) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (w_taken && taken_cnt != C_CNT_MAX) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
